// File: rtl/pipemem_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding, defaults,
// bus command payload and the alignment check.
package pipemem_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned DEFAULT_CW      = 5;
    localparam logic [1:0]  ALIGN_MASK      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pipemem_tmr.sv
// Bus-access timeout counter: cleared on access start, counts BUSY cycles,
// flags the last permitted cycle.
module pipemem_tmr #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipemem.sv
// MIPS32 MEM stage: word loads/stores over a req/ack bus, pipeline stall while
// an access is in flight, alignment and bus-timeout exceptions.
module pipemem
    import pipemem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CW      = DEFAULT_CW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mvalid,
    input  logic              mwmem,
    input  logic              mm2reg,
    input  logic [DATA_W-1:0] malu,
    input  logic [DATA_W-1:0] mb,
    output logic              mstall,
    output logic [DATA_W-1:0] mmo,
    output logic              mexc_align,
    output logic              mexc_bus,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    state_e            state_q, state_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mmo_q, mmo_d;
    logic              memop, mis;
    logic              tmr_clr, tmr_en, tmr_expired;

    assign memop = mvalid & (mwmem | mm2reg);
    assign mis   = is_misaligned(malu[1:0]);

    pipemem_tmr #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_tmr (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_c (tmr_expired)
    );

    // Next-state and register-update logic; ack takes priority over timeout.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        req_d   = req_q;
        err_d   = err_q;
        mmo_d   = mmo_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memop && !mis) begin
                    state_d     = ST_BUSY;
                    req_d       = 1'b1;
                    cmd_d.we    = mwmem;
                    cmd_d.addr  = {malu[DATA_W-1:2], 2'b00};
                    cmd_d.wdata = mb;
                    tmr_clr     = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!cmd_q.we) begin
                        mmo_d = bus_rdata;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!cmd_q.we) begin
                        mmo_d = '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            mmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            err_q   <= err_d;
            mmo_q   <= mmo_d;
        end
    end

    assign mstall     = ((state_q == ST_IDLE) & memop & ~mis) | (state_q == ST_BUSY);
    assign mexc_align = (state_q == ST_IDLE) & memop & mis;
    assign mexc_bus   = (state_q == ST_DONE) & err_q;
    assign mmo        = mmo_q;
    assign bus_req    = req_q;
    assign bus_we     = cmd_q.we;
    assign bus_addr   = cmd_q.addr;
    assign bus_wdata  = cmd_q.wdata;

endmodule

// File: tb/tb_pipemem.sv
// Self-checking bench for pipemem: directed scenarios plus random traffic
// against a per-instruction latency/result model.
module tb_pipemem;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        mvalid, mwmem, mm2reg;
    logic [31:0] malu, mb;
    logic        mstall, mexc_align, mexc_bus;
    logic [31:0] mmo;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mmo = 32'h0;

    always #5 clock = ~clock;

    pipemem #(
        .TIMEOUT (TO),
        .CW      (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mvalid     (mvalid),
        .mwmem      (mwmem),
        .mm2reg     (mm2reg),
        .malu       (malu),
        .mb         (mb),
        .mstall     (mstall),
        .mmo        (mmo),
        .mexc_align (mexc_align),
        .mexc_bus   (mexc_bus),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through MEM; delay<0 means the bus never acks.
    task automatic run_op(input logic v, input logic st, input logic ld,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input logic [31:0] rd, input logic late_ack);
        bit memop, mis, tmo, done;
        int exp_busy, exp_stall, stalls, busy;
        memop     = v && (st || ld);
        mis       = addr[1:0] != 2'b00;
        tmo       = memop && !mis && (delay < 0 || delay >= int'(TO));
        exp_busy  = (!memop || mis) ? 0 : (tmo ? int'(TO) : delay + 1);
        exp_stall = (exp_busy == 0) ? 0 : exp_busy + 1;
        stalls    = 0;
        busy      = 0;
        done      = 1'b0;
        @(posedge clock);
        #1;
        mvalid = v; mwmem = st; mm2reg = ld; malu = addr; mb = wd;
        @(negedge clock);
        chk("align", 32'(mexc_align), 32'(memop && mis));
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clock);
            if (mstall) stalls++;
            if (bus_req) begin
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_we", 32'(bus_we), 32'(st));
                chk("bus_wdata", bus_wdata, wd);
                bus_ack   = (busy == delay);
                bus_rdata = (busy == delay) ? rd : $urandom;
                busy++;
            end else if (!mstall) begin
                done = 1'b1;
                if (exp_busy > 0 && !st) model_mmo = tmo ? 32'h0 : rd;
                chk("stall_cycles", 32'(stalls), 32'(exp_stall));
                chk("busy_cycles", 32'(busy), 32'(exp_busy));
                chk("mmo", mmo, model_mmo);
                chk("mexc_bus", 32'(mexc_bus), 32'(tmo));
                chk("req_end", 32'(bus_req), 32'h0);
                bus_ack   = late_ack;
                bus_rdata = $urandom;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
        chk("op_finished", 32'(done), 32'h1);
    endtask

    initial begin
        int          kind, d;
        logic [31:0] a;
        reset = 1'b1;
        mvalid = 1'b0; mwmem = 1'b0; mm2reg = 1'b0; malu = '0; mb = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_stall", 32'(mstall), 32'h0);
        chk("rst_req", 32'(bus_req), 32'h0);
        chk("rst_we", 32'(bus_we), 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_mmo", mmo, 32'h0);
        chk("rst_exc_bus", 32'(mexc_bus), 32'h0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 3, 32'h5555_AAAA, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 0, 32'h1111_1111, 1'b1);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0, -1, 32'h2222_2222, 1'b1);
        run_op(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 1, 32'hA5A5_0001, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'h0, 2, 32'hA5A5_0002, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_010C, 32'h0, int'(TO) - 1, 32'hC0DE_0003, 1'b0);

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d    = (kind == 3) ? $urandom_range(0, 3) : $urandom_range(0, 5);
            run_op(kind != 0, kind == 3, kind == 2, a, $urandom, d, $urandom,
                   1'($urandom_range(0, 1)));
        end

        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

        // Reset asserted while an access is outstanding.
        @(posedge clock);
        #1;
        mvalid = 1'b1; mwmem = 1'b0; mm2reg = 1'b1; malu = 32'h0000_0040; mb = 32'h0;
        bus_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("busy_req", 32'(bus_req), 32'h1);
        reset = 1'b1;
        #1;
        chk("req_async_drop", 32'(bus_req), 32'h0);
        mvalid = 1'b0; mm2reg = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_mmo = 32'h0;
        #1;
        chk("post_rst_mmo", mmo, model_mmo);
        chk("post_rst_stall", 32'(mstall), 32'h0);
        chk("post_rst_req", 32'(bus_req), 32'h0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_F00D, 1, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0048, 32'h0, 2, 32'h7777_8888, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
